// File: rtl/fitbit_pkg.sv
// Shared constants for the fitbit display scheduler: metric selector codes,
// seven-segment glyphs (active low, bit order {g,f,e,d,c,b,a}), conversion
// FSM states and value saturation helper.
package fitbit_pkg;

  localparam logic [1:0] MODE_STEPS = 2'd0;
  localparam logic [1:0] MODE_DIST  = 2'd1;
  localparam logic [1:0] MODE_INIT  = 2'd2;
  localparam logic [1:0] MODE_HIGH  = 2'd3;

  localparam int unsigned SAT_MAX_DEF = 9999;

  // 9999 fits in 14 bits; four BCD digits need 16 bits
  localparam int BIN_W = 14;
  localparam int BCD_W = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs for digits 0..9, element [n] is digit n
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } conv_state_e;

  // Clamp a metric to the display ceiling; compares at full width before
  // the value is narrowed to the converter width.
  function automatic logic [BIN_W-1:0] sat_val(input logic [31:0] v,
                                               input logic [31:0] smax);
    return (v > smax) ? smax[BIN_W-1:0] : v[BIN_W-1:0];
  endfunction

  // Non-decimal nibbles render as a dark digit
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    if (nib > 4'd9) return SEG_BLANK;
    return SEG_DIGITS[nib];
  endfunction

endpackage

// File: rtl/fitbit_display_ctrl_bin2bcd.sv
// Sequential double-dabble converter. A start pulse in IDLE launches
// LOAD -> CONV (BIN_W iterations) -> DONE; done is high for the DONE cycle
// while bcd holds the finished result.
module bin2bcd_iter
  import fitbit_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e      state, state_nxt;
  logic [BIN_W-1:0] sr;
  logic [BCD_W-1:0] acc, acc_adj;
  logic [3:0]       iter;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: state_nxt = CONV;
      CONV: if (iter == 4'(BIN_W-1)) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every nibble that would overflow past 9 when doubled
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < BCD_W/4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Datapath: capture operand, shift-and-correct, hand result out
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sr   <= '0;
      acc  <= '0;
      iter <= '0;
    end else begin
      case (state)
        LOAD: begin
          sr   <= bin;
          acc  <= '0;
          iter <= '0;
        end
        CONV: begin
          {acc, sr} <= {acc_adj[BCD_W-2:0], sr, 1'b0};
          iter      <= iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/fitbit_display_ctrl.sv
// Display scheduler for the fitbit metrics block. Rotates the shown metric
// (steps, distance, initial activity, high-activity time), converts it to
// BCD and scans a 4-digit active-low seven-segment display.
// Optional macro FITBIT_DISP_BLANK_EN: blank leading zero digits.
module fitbit_display_ctrl
  import fitbit_pkg::*;
#(
  parameter int unsigned ROTATE_DIV = 200000000,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned SAT_MAX    = SAT_MAX_DEF
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] step_count,
  input  logic [15:0] distance_covered,
  input  logic [3:0]  initial_activity_count,
  input  logic [15:0] high_activity_time,
  input  logic        SI,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [1:0]  disp_mode,
  output logic        busy
);

  localparam int RW = (ROTATE_DIV > 1) ? $clog2(ROTATE_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;

  logic [RW-1:0]    rot_cnt;
  logic [SW-1:0]    scan_cnt;
  logic [1:0]       dig_idx;
  logic             rot_tick, scan_tick, scan_wrap;
  logic             pending, start, conv_done;
  logic [BIN_W-1:0] sel_val;
  logic [BCD_W-1:0] conv_bcd, disp_bcd;
  logic [3:0]       nib;
  logic             lead_blank;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  assign rot_tick  = (rot_cnt == RW'(ROTATE_DIV - 1));
  assign scan_tick = (scan_cnt == SW'(SCAN_DIV - 1));
  assign scan_wrap = scan_tick && (dig_idx == 2'd3);

  // Rotation timebase and metric selector
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rot_cnt   <= '0;
      disp_mode <= MODE_STEPS;
    end else if (rot_tick) begin
      rot_cnt   <= '0;
      disp_mode <= disp_mode + 2'd1;
    end else begin
      rot_cnt   <= rot_cnt + RW'(1);
    end
  end

  // Scan timebase and active digit index
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // One-deep refresh request: mode changes and full scan passes merge here
  // and wait for the converter to go idle. Set at reset so the first value
  // appears without waiting a full scan.
  assign start = pending && !busy;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pending <= 1'b1;
    else       pending <= rot_tick || scan_wrap || (pending && !start);
  end

  // Metric mux with saturation; sampled by the converter in its LOAD cycle
  always_comb begin
    sel_val = '0;
    case (disp_mode)
      MODE_STEPS: sel_val = sat_val(step_count, SAT_MAX);
      MODE_DIST:  sel_val = sat_val({16'd0, distance_covered}, SAT_MAX);
      MODE_INIT:  sel_val = sat_val({28'd0, initial_activity_count}, SAT_MAX);
      MODE_HIGH:  sel_val = sat_val({16'd0, high_activity_time}, SAT_MAX);
      default:    sel_val = '0;
    endcase
  end

  bin2bcd_iter u_bcd (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .bin   (sel_val),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Display register only changes on a finished conversion, so the scan
  // never shows a half-converted value
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          disp_bcd <= '0;
    else if (conv_done) disp_bcd <= conv_bcd;
  end

  assign nib = disp_bcd[{dig_idx, 2'b00} +: 4];

`ifdef FITBIT_DISP_BLANK_EN
  // Dark digits above the most significant non-zero digit; the ones digit
  // always shows, and distance keeps the digit before the decimal point
  always_comb begin
    lead_blank = 1'b0;
    case (dig_idx)
      2'd1:    lead_blank = (disp_bcd[15:4] == 12'd0) && (disp_mode != MODE_DIST);
      2'd2:    lead_blank = (disp_bcd[15:8] == 8'd0);
      2'd3:    lead_blank = (disp_bcd[15:12] == 4'd0);
      default: lead_blank = 1'b0;
    endcase
  end
`else
  assign lead_blank = 1'b0;
`endif

  // Next digit drive: one anode low, glyph, decimal point for XXX.X
  // distance or the step-goal marker on the leftmost digit
  always_comb begin
    an_nxt  = ~(4'b0001 << dig_idx);
    seg_nxt = lead_blank ? SEG_BLANK : seg_decode(nib);
    dp_nxt  = 1'b1;
    if (disp_mode == MODE_DIST && dig_idx == 2'd1)
      dp_nxt = 1'b0;
    if (disp_mode == MODE_STEPS && SI && dig_idx == 2'd3)
      dp_nxt = 1'b0;
  end

  // Registered display pins; reset blanks the display immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AN  <= 4'b1111;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      AN  <= an_nxt;
      SEG <= seg_nxt;
      DP  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_fitbit_display_ctrl.sv
// Directed bench for fitbit_display_ctrl with ROTATE_DIV=64, SCAN_DIV=4.
// kk counts negedges since the last reset release; hand-derived schedule:
// conversions LOAD after posedge 1+17j, rotation at posedge 64*n.
module tb_fitbit_display_ctrl;

  logic        CLK, RESET;
  logic [31:0] step_count;
  logic [15:0] distance_covered;
  logic [3:0]  initial_activity_count;
  logic [15:0] high_activity_time;
  logic        SI;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic [1:0]  disp_mode;
  logic        busy;

  int total, bad, kk;

  fitbit_display_ctrl #(.ROTATE_DIV(64), .SCAN_DIV(4), .SAT_MAX(9999)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .step_count             (step_count),
    .distance_covered       (distance_covered),
    .initial_activity_count (initial_activity_count),
    .high_activity_time     (high_activity_time),
    .SI                     (SI),
    .AN                     (AN),
    .SEG                    (SEG),
    .DP                     (DP),
    .disp_mode              (disp_mode),
    .busy                   (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [6:0] dseg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int val, input int i, input int mode);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
`ifdef FITBIT_DISP_BLANK_EN
    if (i > 0 && val < p && !(mode == 1 && i == 1)) return 7'h7F;
`endif
    return dseg((val / p) % 10);
  endfunction

  task automatic tick();
    @(negedge CLK);
    kk++;
  endtask

  task automatic wait_to(input int k);
    while (kk < k) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    kk = 0;
  endtask

  // Observe one full scan pass, collecting glyph and DP per anode
  task automatic read_display(output logic [3:0][6:0] s, output logic [3:0] d,
                              output int nbad);
    s = '0; d = '0; nbad = 0;
    repeat (16) begin
      tick();
      case (AN)
        4'b1110: begin s[0] = SEG; d[0] = DP; end
        4'b1101: begin s[1] = SEG; d[1] = DP; end
        4'b1011: begin s[2] = SEG; d[2] = DP; end
        4'b0111: begin s[3] = SEG; d[3] = DP; end
        default: nbad++;
      endcase
    end
  endtask

  task automatic test_reset();
    step_count = 32'd1234; distance_covered = 16'd57;
    initial_activity_count = 4'd15; high_activity_time = 16'd120; SI = 1'b0;
    RESET = 1'b1;
    tick();
    total++; if (AN !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", AN); end
    total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", SEG); end
    total++; if (DP !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", DP); end
    total++; if (disp_mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", disp_mode); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    RESET = 1'b0;
    kk = 0;
  endtask

  task automatic test_first_conv();
    int nbusy, nb;
    logic [3:0] ean;
    logic [3:0][6:0] s;
    logic [3:0] d;
    nbusy = 0;
    while (kk < 17) begin
      tick();
      if (kk <= 16 && busy === 1'b1) nbusy++;
      if (kk % 4 == 1 && kk <= 13) begin
        ean = ~(4'b0001 << ((kk - 1) / 4));
        total++; if (AN !== ean) begin bad++; $display("FAIL scan_an k=%0d got=%b exp=%b", kk, AN, ean); end
      end
      if (kk == 1) begin
        total++; if (SEG !== 7'h40) begin bad++; $display("FAIL pre_conv_seg got=%h exp=40", SEG); end
      end
      if (kk == 17) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_busy_end got=%b exp=0", busy); end
      end
    end
    total++; if (nbusy != 16) begin bad++; $display("FAIL first_busy_len got=%0d exp=16", nbusy); end
    read_display(s, d, nb);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (s[i] !== exp_seg(1234, i, 0)) begin bad++; $display("FAIL steps1234_dig%0d got=%h exp=%h", i, s[i], exp_seg(1234, i, 0)); end
    end
    total++; if (d !== 4'b1111) begin bad++; $display("FAIL steps1234_dp got=%b exp=1111", d); end
    total++; if (nb != 0) begin bad++; $display("FAIL steps1234_an got=%0d exp=0 bad anode samples", nb); end
  endtask

  task automatic test_rot_during_conv();
    int rises;
    logic prev;
    wait_to(63);
    total++; if (disp_mode !== 2'd0) begin bad++; $display("FAIL pre_rot_mode got=%0d exp=0", disp_mode); end
    tick();
    total++; if (disp_mode !== 2'd1) begin bad++; $display("FAIL rot1_mode got=%0d exp=1", disp_mode); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rot_in_conv_busy got=%b exp=1", busy); end
    prev = busy;
    rises = 0;
    while (kk < 85) begin
      tick();
      if (busy && !prev) rises++;
      prev = busy;
      if (kk == 68) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL old_conv_end got=%b exp=0", busy); end
      end
      if (kk == 85) begin
        total++; if (SEG !== dseg(3)) begin bad++; $display("FAIL old_value_held got=%h exp=%h", SEG, dseg(3)); end
        total++; if (DP !== 1'b0) begin bad++; $display("FAIL dist_dp_k85 got=%b exp=0", DP); end
      end
    end
    total++; if (rises != 1) begin bad++; $display("FAIL extra_conv_count got=%0d exp=1", rises); end
    tick();
    total++; if (SEG !== exp_seg(57, 1, 1)) begin bad++; $display("FAIL new_value_k86 got=%h exp=%h", SEG, exp_seg(57, 1, 1)); end
  endtask

  task automatic test_distance();
    int nb;
    logic [3:0][6:0] s;
    logic [3:0] d;
    wait_to(94);
    read_display(s, d, nb);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (s[i] !== exp_seg(57, i, 1)) begin bad++; $display("FAIL dist57_dig%0d got=%h exp=%h", i, s[i], exp_seg(57, i, 1)); end
    end
    total++; if (d !== 4'b1101) begin bad++; $display("FAIL dist57_dp got=%b exp=1101", d); end
    total++; if (nb != 0) begin bad++; $display("FAIL dist57_an got=%0d exp=0 bad anode samples", nb); end
  endtask

  task automatic test_mode_cycle();
    int nb;
    int mv[3];
    int ev[3];
    logic [3:0][6:0] s;
    logic [3:0] d;
    mv[0] = 2; mv[1] = 3; mv[2] = 0;
    ev[0] = 15; ev[1] = 120; ev[2] = 1234;
    for (int n = 0; n < 3; n++) begin
      wait_to(64 * (n + 2));
      total++; if (disp_mode !== 2'(mv[n])) begin bad++; $display("FAIL rot_mode k=%0d got=%0d exp=%0d", kk, disp_mode, mv[n]); end
      wait_to(64 * (n + 2) + 30);
      read_display(s, d, nb);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (s[i] !== exp_seg(ev[n], i, mv[n])) begin bad++; $display("FAIL mode%0d_dig%0d got=%h exp=%h", mv[n], i, s[i], exp_seg(ev[n], i, mv[n])); end
      end
      total++; if (d !== 4'b1111) begin bad++; $display("FAIL mode%0d_dp got=%b exp=1111", mv[n], d); end
      total++; if (nb != 0) begin bad++; $display("FAIL mode%0d_an got=%0d exp=0 bad anode samples", mv[n], nb); end
    end
  endtask

  task automatic test_saturation();
    int nb;
    logic [31:0] vin[5];
    int vexp[5];
    logic vsi[5];
    logic [3:0] edp;
    logic [3:0][6:0] s;
    logic [3:0] d;
    vin[0] = 32'd100000; vexp[0] = 9999; vsi[0] = 1'b1;
    vin[1] = 32'd65541;  vexp[1] = 9999; vsi[1] = 1'b0;
    vin[2] = 32'd10000;  vexp[2] = 9999; vsi[2] = 1'b0;
    vin[3] = 32'd9998;   vexp[3] = 9998; vsi[3] = 1'b0;
    vin[4] = 32'd7;      vexp[4] = 7;    vsi[4] = 1'b0;
    for (int v = 0; v < 5; v++) begin
      step_count = vin[v];
      SI = vsi[v];
      do_reset();
      wait_to(17);
      read_display(s, d, nb);
      edp = vsi[v] ? 4'b0111 : 4'b1111;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (s[i] !== exp_seg(vexp[v], i, 0)) begin bad++; $display("FAIL sat_in%0d_dig%0d got=%h exp=%h", vin[v], i, s[i], exp_seg(vexp[v], i, 0)); end
      end
      total++; if (d !== edp) begin bad++; $display("FAIL sat_in%0d_dp got=%b exp=%b", vin[v], d, edp); end
      total++; if (nb != 0) begin bad++; $display("FAIL sat_in%0d_an got=%0d exp=0 bad anode samples", vin[v], nb); end
    end
    SI = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    int nbusy, nb;
    logic [3:0][6:0] s;
    logic [3:0] d;
    step_count = 32'd4321;
    do_reset();
    wait_to(9);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midconv_busy got=%b exp=1", busy); end
    RESET = 1'b1;
    #1;
    total++; if (AN !== 4'b1111) begin bad++; $display("FAIL async_an got=%b exp=1111", AN); end
    total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL async_seg got=%h exp=7f", SEG); end
    total++; if (DP !== 1'b1) begin bad++; $display("FAIL async_dp got=%b exp=1", DP); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b exp=0", busy); end
    total++; if (disp_mode !== 2'd0) begin bad++; $display("FAIL async_mode got=%0d exp=0", disp_mode); end
    tick();
    RESET = 1'b0;
    kk = 0;
    nbusy = 0;
    while (kk < 17) begin
      tick();
      if (kk <= 16 && busy === 1'b1) nbusy++;
      if (kk == 17) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rerun_busy_end got=%b exp=0", busy); end
      end
    end
    total++; if (nbusy != 16) begin bad++; $display("FAIL rerun_busy_len got=%0d exp=16", nbusy); end
    read_display(s, d, nb);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (s[i] !== exp_seg(4321, i, 0)) begin bad++; $display("FAIL rerun4321_dig%0d got=%h exp=%h", i, s[i], exp_seg(4321, i, 0)); end
    end
    total++; if (nb != 0) begin bad++; $display("FAIL rerun4321_an got=%0d exp=0 bad anode samples", nb); end
  endtask

  initial begin
    total = 0; bad = 0; kk = 0;
    test_reset();
    test_first_conv();
    test_rot_during_conv();
    test_distance();
    test_mode_cycle();
    test_saturation();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fitbit_display_ctrl.md
Name: fitbit_display_ctrl

Overview:
Display scheduler for the fitbit metrics block. It rotates the shown metric every rotate period: steps, distance, initial activity, then high-activity time. It converts the selected binary value to BCD using a sequential double-dabble FSM. It drives a 4-digit, common-anode, active-low seven-segment display by time-multiplexed digit scanning.

Parameters:
ROTATE_DIV, 200000000, clock cycles per metric rotation (2 s at 100 MHz).
SCAN_DIV, 100000, clock cycles per digit in the scan (1 kHz digit rate).
SAT_MAX, 9999, saturation ceiling for every displayed value.

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-high reset.
step_count  in  32  step total.
distance_covered  in  16  distance in tenths of a mile (fixed point, 1 fractional digit).
initial_activity_count  in  4  initial activity seconds.
high_activity_time  in  16  high-activity seconds.
SI  in  1  step-goal indicator.
AN  out  4  digit anodes, active low.
SEG  out  7  segments {g,f,e,d,c,b,a}, active low.
DP  out  1  decimal point, active low.
disp_mode  out  2  metric selector: 0 steps, 1 distance, 2 initial, 3 high.
busy  out  1  high while the conversion FSM is not IDLE.

Behaviour:
- Reset state: AN=4'b1111, SEG=7'h7F, DP=1, disp_mode=0, busy=0, BCD display register=0, rotate/scan counters=0, digit index=0, FSM=IDLE, pending=1. The first conversion runs immediately after reset deasserts.
- Rotate counter:
  - Counts 0..ROTATE_DIV-1.
  - At terminal count it issues a 1-cycle rot_tick.
  - On rot_tick, disp_mode increments and wraps 3→0, and pending is set.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - At terminal count the digit index increments 0→3→0.
  - When the index wraps 3→0, pending is set to refresh live values.
  - rot_tick and the scan wrap in the same cycle set pending once.
- Conversion FSM states: IDLE, LOAD, CONV, DONE.
  - IDLE: if pending=1, clear pending and go to LOAD.
  - LOAD: select the input by disp_mode and saturate it: value > SAT_MAX → SAT_MAX. Compare step_count at full 32 bits before truncation. Load a 14-bit shift register, clear the 16-bit BCD accumulator and the iteration counter.
  - CONV: exactly 14 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift left by 1 with the binary MSB entering the accumulator LSB.
  - DONE: copy the accumulator atomically into the display register, then return to IDLE.
  - Latency: pending seen in IDLE at cycle t → display register updated at end of cycle t+16.
- pending set while busy: held (one deep, extra requests merge) and serviced on the next IDLE. A mode change mid-conversion keeps showing the old value until the following DONE.
- Digit drive, registered:
  - AN[i]=0 only for i = digit index.
  - SEG = decode of display nibble i; nibbles >9 show blank.
  - DP=0 when disp_mode=1 and index=1, giving the XXX.X format.
  - DP=0 when disp_mode=0, SI=1 and index=3 (goal reached).
  - DP=1 otherwise.
- Reset asserted mid-conversion: immediate async return to the reset state; the display blanks.

Optional Feature:
Macro FITBIT_DISP_BLANK_EN.
- Defined: leading-zero blanking. Digits above the most significant non-zero digit show SEG=7'h7F.
  - Digit 0 is never blanked.
  - In distance mode, digit 1 is never blanked either (value 5 shows " 0.5").
- Undefined: all four digits always show, including leading zeros.

Decomposition:
- Package fitbit_pkg:
  - mode encodings: MODE_STEPS=0, MODE_DIST=1, MODE_INIT=2, MODE_HIGH=3.
  - SEG_BLANK=7'h7F.
  - the 10-entry seven-segment digit constants.
  - SAT_MAX default.
- Sub-module bin2bcd_iter: sequential double-dabble with start/done handshake, wrapping the LOAD/CONV/DONE datapath. The top level keeps the counters, pending logic, mode register and scan drive.

Test Plan:
Run all scenarios with ROTATE_DIV=64 and SCAN_DIV=4.
1. Reset release, step_count=1234 → busy for 16 cycles, then display register=16'h1234. Scanning shows AN=1110,1101,1011,0111 with SEG for 4,3,2,1.
2. step_count=32'd100000 → shows 9999. With SI=1, DP=0 only while AN=0111.
3. Wait for rot_tick with distance_covered=57 → disp_mode=1, display 0057, DP low on digit 1. With FITBIT_DISP_BLANK_EN defined, digits 3 and 2 are blank.
4. rot_tick issued during CONV → display shows the old metric until DONE. A second conversion starts in the next IDLE and yields the new metric. Exactly one extra conversion runs.
5. Four rot_ticks → disp_mode sequence 1,2,3,0. initial_activity_count=15 shows 0015, high_activity_time=120 shows 0120.
6. RESET asserted at CONV iteration 7 → outputs go to reset values the same cycle, without waiting for a clock edge. After release, a fresh conversion completes 16 cycles later.
